// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one SDRAM controller slave between two Avalon-MM masters:
//   port 0 is the Nios II data master and port 1 is the frame/DMA master.
//   Grants alternate round-robin, and only one command is in flight to the
//   slave at any time. Pipelined reads are supported: a small ID FIFO
//   remembers which port issued each read so that every readdatavalid
//   is routed back to the correct issuer.
//
//   Optional build macro SDRAM_ARB_STATS_EN adds saturating 16-bit
//   counters m0_grant_cnt, m1_grant_cnt and wait_cnt.
//
//   Handshake (Avalon-MM): a master holds read/write and its command fields
//   stable while waitrequest=1. The command is taken in the one cycle where
//   waitrequest=0. Towards the slave, the same rule applies with
//   s_waitrequest. Read data returns later, in issue order, on
//   s_readdatavalid.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int PEND_DEPTH = 8,
  localparam int BE_W      = DATA_W / 8,
  localparam int PTR_W     = $clog2(PEND_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic [CNT_W-1:0]  pend_count,
  output logic              err_orphan
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [15:0]       m0_grant_cnt,
  output logic [15:0]       m1_grant_cnt,
  output logic [15:0]       wait_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nx;
  logic             owner, owner_nx;   // 0 = port 0, 1 = port 1
  logic             last, last_nx;     // port served most recently
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             id_mem [PEND_DEPTH];

  logic fifo_full, fifo_empty;
  logic m0_elig, m1_elig;
  logic own_read, own_write, own_req;
  logic accept, push, pop, head;

  assign fifo_full  = (pend_count == CNT_W'(PEND_DEPTH));
  assign fifo_empty = (pend_count == '0);

  // A port that asserts read and write together is handled as a reader,
  // so it must also wait for FIFO space.
  assign m0_elig = m0_read ? ~fifo_full : m0_write;
  assign m1_elig = m1_read ? ~fifo_full : m1_write;

  // Owner's live request, steered to the slave.
  assign own_read  = owner ? m1_read : m0_read;
  assign own_write = (owner ? m1_write : m0_write) & ~own_read;
  assign own_req   = own_read | own_write;

  assign s_address    = owner ? m1_address    : m0_address;
  assign s_writedata  = owner ? m1_writedata  : m0_writedata;
  assign s_byteenable = owner ? m1_byteenable : m0_byteenable;
  assign s_read       = (state == BUSY) & own_read;
  assign s_write      = (state == BUSY) & own_write;

  assign accept = (state == BUSY) & own_req & ~s_waitrequest;
  assign push   = accept & own_read;
  assign pop    = s_readdatavalid & ~fifo_empty;
  assign head   = id_mem[rd_ptr];

  assign m0_waitrequest = ~(accept & ~owner);
  assign m1_waitrequest = ~(accept & owner);

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;

  // FSM state, owner and round-robin pointer registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
    end
  end

  // Grant selection in IDLE, completion or abandonment in BUSY.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (m0_elig && m1_elig) begin
          owner_nx = ~last;
          state_nx = BUSY;
        end else if (m0_elig) begin
          owner_nx = 1'b0;
          state_nx = BUSY;
        end else if (m1_elig) begin
          owner_nx = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          last_nx  = owner;
          state_nx = IDLE;
        end else if (!own_req) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ID FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk_clk) begin
    if (push) id_mem[wr_ptr] <= owner;
  end

  // ID FIFO pointers, occupancy and the sticky orphan-return flag.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pend_count <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   pend_count <= pend_count + CNT_W'(1);
        2'b01:   pend_count <= pend_count - CNT_W'(1);
        default: pend_count <= pend_count;
      endcase
      if (s_readdatavalid && fifo_empty) err_orphan <= 1'b1;
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic any_wait;
  assign any_wait = ((m0_read | m0_write) & m0_waitrequest) |
                    ((m1_read | m1_write) & m1_waitrequest);

  // Saturating grant and stall counters.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
      wait_cnt     <= '0;
    end else begin
      if (accept && !owner && m0_grant_cnt != 16'hFFFF) m0_grant_cnt <= m0_grant_cnt + 16'd1;
      if (accept && owner && m1_grant_cnt != 16'hFFFF)  m1_grant_cnt <= m1_grant_cnt + 16'd1;
      if (any_wait && wait_cnt != 16'hFFFF)             wait_cnt     <= wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model (busy flag, owner, last-served port, queue of pending
//   read IDs) predicts every cycle's slave command, waitrequests, read
//   routing, pend_count and err_orphan.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int PEND_DEPTH = 8;
  localparam int BE_W = DATA_W / 8;
  localparam int CNT_W = $clog2(PEND_DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  always #5 clk_clk = ~clk_clk;

  // ---------------- DUT hookup ----------------
  logic [ADDR_W-1:0] d_addr [2];
  logic              d_rd   [2];
  logic              d_wr   [2];
  logic [DATA_W-1:0] d_wd   [2];
  logic [BE_W-1:0]   d_be   [2];

  wire [ADDR_W-1:0] m0_address = d_addr[0];
  wire              m0_read = d_rd[0];
  wire              m0_write = d_wr[0];
  wire [DATA_W-1:0] m0_writedata = d_wd[0];
  wire [BE_W-1:0]   m0_byteenable = d_be[0];
  wire [ADDR_W-1:0] m1_address = d_addr[1];
  wire              m1_read = d_rd[1];
  wire              m1_write = d_wr[1];
  wire [DATA_W-1:0] m1_writedata = d_wd[1];
  wire [BE_W-1:0]   m1_byteenable = d_be[1];

  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] s_address;
  logic              s_read, s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic [CNT_W-1:0]  pend_count;
  logic              err_orphan;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] m0_grant_cnt, m1_grant_cnt, wait_cnt;
`endif

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PEND_DEPTH(PEND_DEPTH)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .pend_count(pend_count), .err_orphan(err_orphan)
`ifdef SDRAM_ARB_STATS_EN
    , .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt), .wait_cnt(wait_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_busy, m_owner, m_last, m_orph;
  bit id_q[$];
  bit acc_g[2];
  int m_g0, m_g1, m_wc;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 1; m_orph = 0;
    id_q.delete();
    acc_g[0] = 0; acc_g[1] = 0;
    m_g0 = 0; m_g1 = 0; m_wc = 0;
  endtask

  // Check one cycle at the falling edge, then advance the model to the
  // next cycle. Returns 1 ns after the following rising edge.
  task automatic step();
    int cnt;
    bit rd[2], wr[2], rq[2], ev[2], el[2];
    bit o;
    @(negedge clk_clk);
    cnt = id_q.size();
    o = m_owner;
    for (int n = 0; n < 2; n++) begin
      rd[n] = d_rd[n]; wr[n] = d_wr[n]; rq[n] = rd[n] | wr[n];
      acc_g[n] = 0; ev[n] = 0;
    end
    if (m_busy) begin
      check("s_read", 32'(s_read), 32'(rd[o]));
      check("s_write", 32'(s_write), 32'(wr[o] & ~rd[o]));
      if (rq[o]) begin
        check("s_address", 32'(s_address), 32'(d_addr[o]));
        check("s_writedata", 32'(s_writedata), 32'(d_wd[o]));
        check("s_byteenable", 32'(s_byteenable), 32'(d_be[o]));
      end
      acc_g[o] = rq[o] & ~s_waitrequest;
    end else begin
      check("s_read_idle", 32'(s_read), 32'd0);
      check("s_write_idle", 32'(s_write), 32'd0);
    end
    check("m0_waitrequest", 32'(m0_waitrequest), 32'(!acc_g[0]));
    check("m1_waitrequest", 32'(m1_waitrequest), 32'(!acc_g[1]));
    if (s_readdatavalid && cnt > 0) ev[id_q[0]] = 1;
    check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(ev[0]));
    check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(ev[1]));
    if (ev[0]) check("m0_readdata", 32'(m0_readdata), 32'(s_readdata));
    if (ev[1]) check("m1_readdata", 32'(m1_readdata), 32'(s_readdata));
    check("pend_count", 32'(pend_count), 32'(cnt));
    check("err_orphan", 32'(err_orphan), 32'(m_orph));
`ifdef SDRAM_ARB_STATS_EN
    check("m0_grant_cnt", 32'(m0_grant_cnt), 32'(m_g0));
    check("m1_grant_cnt", 32'(m1_grant_cnt), 32'(m_g1));
    check("wait_cnt", 32'(wait_cnt), 32'(m_wc));
    if (acc_g[0] && m_g0 < 65535) m_g0++;
    if (acc_g[1] && m_g1 < 65535) m_g1++;
    if (((rq[0] && !acc_g[0]) || (rq[1] && !acc_g[1])) && m_wc < 65535) m_wc++;
`endif
    // advance model
    if (s_readdatavalid) begin
      if (cnt > 0) void'(id_q.pop_front());
      else m_orph = 1;
    end
    if (m_busy) begin
      if (acc_g[o]) begin
        m_busy = 0; m_last = o;
        if (rd[o]) id_q.push_back(o);
      end else if (!rq[o]) begin
        m_busy = 0;
      end
    end else begin
      for (int n = 0; n < 2; n++) el[n] = rd[n] ? (cnt < PEND_DEPTH) : wr[n];
      if (el[0] && el[1]) begin m_busy = 1; m_owner = ~m_last; end
      else if (el[0]) begin m_busy = 1; m_owner = 0; end
      else if (el[1]) begin m_busy = 1; m_owner = 1; end
    end
    @(posedge clk_clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  bit act[2];

  task automatic clear_inputs();
    for (int n = 0; n < 2; n++) begin
      d_addr[n] = '0; d_rd[n] = 0; d_wr[n] = 0; d_wd[n] = '0; d_be[n] = '0; act[n] = 0;
    end
    s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_reset = 1;
    model_reset();
    repeat (2) @(posedge clk_clk);
    #1;
    check("rst_s_read", 32'(s_read), 32'd0);
    check("rst_s_write", 32'(s_write), 32'd0);
    check("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    check("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    check("rst_m0_rdv", 32'(m0_readdatavalid), 32'd0);
    check("rst_m1_rdv", 32'(m1_readdatavalid), 32'd0);
    check("rst_pend", 32'(pend_count), 32'd0);
    check("rst_orphan", 32'(err_orphan), 32'd0);
`ifdef SDRAM_ARB_STATS_EN
    check("rst_g0", 32'(m0_grant_cnt), 32'd0);
    check("rst_g1", 32'(m1_grant_cnt), 32'd0);
    check("rst_wc", 32'(wait_cnt), 32'd0);
`endif
    reset_reset = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gq[$];
    int exp_ord[4];
    logic [DATA_W-1:0] rdat[4];
    int k, p;

    // Single write from port 0.
    do_reset();
    d_wr[0] = 1; d_addr[0] = 25'h0000123; d_wd[0] = 16'hBEEF; d_be[0] = 2'b11;
    step();
    check("t1_s_write", 32'(s_write), 32'd1);
    check("t1_s_address", 32'(s_address), 32'h123);
    check("t1_s_writedata", 32'(s_writedata), 32'hBEEF);
    check("t1_s_byteenable", 32'(s_byteenable), 32'h3);
    check("t1_m0_wait", 32'(m0_waitrequest), 32'd0);
    step();
    d_wr[0] = 0;
    check("t1_m0_wait_after", 32'(m0_waitrequest), 32'd1);
    check("t1_pend", 32'(pend_count), 32'd0);
    step();

    // Tie from reset: alternating grants, then in-order routed returns.
    do_reset();
    d_rd[0] = 1; d_addr[0] = 25'h10; d_rd[1] = 1; d_addr[1] = 25'h20;
    for (int c = 0; c < 16 && gq.size() < 4; c++) begin
      step();
      if (acc_g[0]) gq.push_back(0);
      if (acc_g[1]) gq.push_back(1);
    end
    d_rd[0] = 0; d_rd[1] = 0;
    exp_ord = '{0, 1, 0, 1};
    check("t2_ngrants", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) check("t2_grant_order", 32'(gq[i]), 32'(exp_ord[i]));
    check("t2_pend4", 32'(pend_count), 32'd4);
    rdat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) exp_q.push_back(rdat[i]);
    for (int i = 0; i < 4; i++) begin
      s_readdatavalid = 1; s_readdata = rdat[i];
      #1;
      if (exp_ord[i] == 0) begin
        check("t2_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        check("t2_m0_data", 32'(m0_readdata), 32'(exp_q.pop_front()));
      end else begin
        check("t2_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        check("t2_m1_data", 32'(m1_readdata), 32'(exp_q.pop_front()));
      end
      step();
    end
    s_readdatavalid = 0;
    step();

    // Orphan return sets a sticky error.
    do_reset();
    s_readdatavalid = 1; s_readdata = 16'hDEAD;
    #1;
    check("t5_m0_rdv", 32'(m0_readdatavalid), 32'd0);
    check("t5_m1_rdv", 32'(m1_readdatavalid), 32'd0);
    step();
    s_readdatavalid = 0;
    check("t5_orphan", 32'(err_orphan), 32'd1);
    repeat (3) step();
    check("t5_orphan_held", 32'(err_orphan), 32'd1);

    // Reset while a port 0 read is stalled.
    do_reset();
    d_rd[0] = 1; d_addr[0] = 25'h55;
    step(); step();
    s_waitrequest = 1;
    step(); step(); step();
    check("t6_pend1", 32'(pend_count), 32'd1);
    check("t6_s_read_stalled", 32'(s_read), 32'd1);
    #2 reset_reset = 1;
    #1;
    check("t6_s_read", 32'(s_read), 32'd0);
    check("t6_m0_wait", 32'(m0_waitrequest), 32'd1);
    check("t6_pend0", 32'(pend_count), 32'd0);
`ifdef SDRAM_ARB_STATS_EN
    check("t6_g0", 32'(m0_grant_cnt), 32'd0);
    check("t6_wc", 32'(wait_cnt), 32'd0);
`endif

    // Randomized traffic: moderate returns first, then sparse returns so
    // the pending-read FIFO fills and read requesters stall.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && $urandom_range(0, 99) < 40) begin
          act[n] = 1;
          k = $urandom_range(0, 9);
          d_rd[n] = (k < 5) || (k == 9);
          d_wr[n] = (k >= 5);
          d_addr[n] = ADDR_W'($urandom);
          d_wd[n] = DATA_W'($urandom);
          d_be[n] = BE_W'($urandom);
        end
      end
      s_waitrequest = ($urandom_range(0, 99) < 30);
      p = (c < 2000) ? 50 : 8;
      s_readdatavalid = (id_q.size() > 0) && ($urandom_range(0, 99) < p);
      s_readdata = DATA_W'($urandom);
      step();
      for (int n = 0; n < 2; n++) begin
        if (acc_g[n]) begin
          act[n] = 0; d_rd[n] = 0; d_wr[n] = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Two-port Avalon-MM arbiter sharing the single SDRAM controller slave between the Nios II data master (port 0) and a frame/DMA master (port 1).
- Round-robin grant, one command in flight to the slave at a time.
- Pipelined reads supported: an ID FIFO routes each readdatavalid back to its issuer.
- Sits between the requesters and the SDRAM controller in the DE1-SoC system, clocked from the SDRAM-side PLL clock.

Parameters:
ADDR_W, 25, word address width (32M x 16 SDRAM)
DATA_W, 16, data width; byteenable width BE_W = DATA_W/8
PEND_DEPTH, 8, maximum outstanding reads (power of 2, >=2)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  reset, asynchronous, active-high
m0_address  in  ADDR_W  port 0 address
m0_read  in  1  port 0 read request
m0_write  in  1  port 0 write request
m0_writedata  in  DATA_W  port 0 write data
m0_byteenable  in  BE_W  port 0 byte enables
m0_waitrequest  out  1  port 0 stall
m0_readdata  out  DATA_W  port 0 read data
m0_readdatavalid  out  1  port 0 read data strobe
m1_*  same set as m0_*, for port 1
s_address  out  ADDR_W  to SDRAM controller
s_read  out  1  to SDRAM controller
s_write  out  1  to SDRAM controller
s_writedata  out  DATA_W  to SDRAM controller
s_byteenable  out  BE_W  to SDRAM controller
s_waitrequest  in  1  from SDRAM controller
s_readdata  in  DATA_W  from SDRAM controller
s_readdatavalid  in  1  from SDRAM controller
pend_count  out  log2(PEND_DEPTH)+1  outstanding read count
err_orphan  out  1  sticky: readdatavalid received with no pending read

Behaviour:
- Reset values (async, immediate):
  - state IDLE; m0/m1_waitrequest=1; m*_readdatavalid=0.
  - s_read=0, s_write=0; ID FIFO empty; pend_count=0; err_orphan=0.
  - last-served pointer = port 1, so port 0 wins the first tie.
- Port n is eligible when it asserts write, or asserts read while pend_count<PEND_DEPTH. Read and write asserted together by one port is illegal; it is treated as a read.
- State IDLE:
  - If no port is eligible: stay in IDLE.
  - If one port is eligible: register owner = that port, go to BUSY.
  - If both are eligible: owner = port other than last-served, go to BUSY.
  - s_read/s_write=0 in IDLE.
- State BUSY:
  - s_address, s_writedata, s_byteenable, s_read, s_write are driven combinationally from the owner's live inputs.
  - Acceptance = owner request asserted and s_waitrequest=0.
  - On acceptance: owner waitrequest=0 for that cycle only; last-served=owner; state goes to IDLE.
  - On acceptance of a read: push owner ID into the FIFO.
  - If the owner deasserts its request while in BUSY (protocol violation): return to IDLE next cycle, no command issued, pointer unchanged.
- m*_waitrequest is 1 in every cycle except the owner's acceptance cycle.
- Throughput: at most one command per 2 cycles. Minimum request-to-accept latency is 1 cycle (request at cycle 0, accepted at cycle 1 at the earliest).
- Read return:
  - s_readdata fans out to both m0_readdata and m1_readdata, combinationally.
  - On s_readdatavalid=1: pop the FIFO head; assert m<head>_readdatavalid in the same cycle.
  - Return order equals issue order.
- Boundaries:
  - Push and pop in the same cycle: pend_count unchanged.
  - FIFO full: reads are not granted; writes still proceed; a read requester stays stalled.
  - s_readdatavalid with FIFO empty: no readdatavalid to either port; err_orphan set to 1 and held until reset.
  - FIFO pointers wrap modulo PEND_DEPTH.
  - Reset mid-operation: all state is dropped at once; the SDRAM controller shares the same reset.

Optional Feature:
SDRAM_ARB_STATS_EN
- Defined: adds three outputs, all 16-bit, saturating at 0xFFFF, reset to 0.
  - m0_grant_cnt: +1 per port 0 acceptance.
  - m1_grant_cnt: +1 per port 1 acceptance.
  - wait_cnt: +1 per cycle in which any port has waitrequest=1 while requesting.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Single write: m0 writes addr 0x0000123, data 0xBEEF, be 2'b11, s_waitrequest=0 -> s_write=1 with those values in cycle 1; m0_waitrequest=0 in cycle 1 only; pend_count stays 0.
2. Tie: m0 and m1 both read from reset -> grants in order m0, m1, m0, m1 over 4 commands; pend_count reaches 4. Slave returns 0x1111, 0x2222, 0x3333, 0x4444 -> m0 gets 0x1111 and 0x3333; m1 gets 0x2222 and 0x4444.
3. Slave stall: s_waitrequest=1 for 5 cycles during an m1 read -> s_address stable; m1_waitrequest=1 for 6 cycles; m0 write requested meanwhile is granted only after m1 is accepted.
4. FIFO full: 8 m0 reads with no return -> 9th m0 read stalls, pend_count=8. m1 write is still accepted. One readdatavalid -> 9th read accepted; pend_count stays 8 if push and pop coincide.
5. Orphan: s_readdatavalid=1 with pend_count=0 -> no m*_readdatavalid; err_orphan=1 and it stays 1. Reset -> err_orphan=0.
6. Reset mid-BUSY: assert reset_reset while an m0 read is stalled -> s_read=0 and m0_waitrequest=1 immediately; pend_count=0. With SDRAM_ARB_STATS_EN defined, all counters return to 0.
